// File: rtl/ctu_synch_ratio_fifo.sv
// ctu_synch_ratio_fifo
// Ratio-synchronous crossing buffer on cmp_clk. Source samples are captured
// on rx_sync pulses into a 2**AW-entry queue and released to the destination
// on tx_sync pulses, which absorbs phase drift between the two pulse trains.
// The output data/valid, occupancy and sticky overflow all come straight
// from flops, so no input reaches an output combinationally.
module ctu_synch_ratio_fifo #(
  parameter int SIZE = 1,  // data width, 1..128
  parameter int AW   = 2   // address width, depth = 2**AW, 1..4
) (
  input  logic            cmp_clk,
  input  logic            arst,
  input  logic            flush,
  input  logic            rx_sync,
  input  logic            prevld,
  input  logic [SIZE-1:0] presyncdata,
  input  logic            tx_sync,
  output logic [SIZE-1:0] syncdata,
  output logic            syncvld,
  output logic [AW:0]     occupancy,
  output logic            overflow
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Storage and registered state. Pointers carry one extra wrap bit so that
  // full and empty can be told apart when the index bits match.
  logic [SIZE-1:0] mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            vld_q, vld_d;
  logic            ovf_q, ovf_d;

  // Queue status and transfer qualifiers, all derived from registered state.
  logic            empty;
  logic            full;
  logic            rd_en;
  logic            wr_en;
  logic            drop;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Empty/full decode and read/write enables. A write into a full queue is
  // still accepted when the same edge pops the head, so nothing is dropped.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    rd_en = tx_sync & ~empty;
    wr_en = rx_sync & prevld & (~full | rd_en);
    drop  = rx_sync & prevld & full & ~rd_en;
  end

  // Next-state computation; flush overrides any concurrent read or write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    vld_d    = vld_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      data_d   = '0;
      vld_d    = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        data_d   = mem_q[rd_idx];
        vld_d    = 1'b1;
      end else if (tx_sync) begin
        // Destination sampled an empty queue: drop valid, hold the data.
        vld_d = 1'b0;
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
    // Modulo 2**(AW+1) difference of the post-edge pointers.
    occ_d = wr_ptr_d - rd_ptr_d;
  end

  // Queue storage write.
  // NOTE: the array is deliberately left out of reset; empty/full come from
  // the pointers, so stale contents are never observed and the array can map
  // to plain flops or RAM without a reset network.
  always_ff @(posedge cmp_clk) begin
    if (wr_en && !flush) begin
      mem_q[wr_idx] <= presyncdata;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge cmp_clk or posedge arst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end

  assign syncdata  = data_q;
  assign syncvld   = vld_q;
  assign occupancy = occ_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ctu_synch_ratio_fifo.sv
// Directed bench for ctu_synch_ratio_fifo with SIZE=8, AW=2 (depth 4).
// Inputs change #1 after a rising edge; outputs are sampled at the same
// point, i.e. after the edge that ends each stimulus cycle.
module tb_ctu_synch_ratio_fifo;

  localparam int SIZE = 8;
  localparam int AW   = 2;

  logic            cmp_clk = 1'b0;
  logic            arst;
  logic            flush;
  logic            rx_sync;
  logic            prevld;
  logic [SIZE-1:0] presyncdata;
  logic            tx_sync;
  logic [SIZE-1:0] syncdata;
  logic            syncvld;
  logic [AW:0]     occupancy;
  logic            overflow;

  int errors = 0;
  int checks = 0;

  ctu_synch_ratio_fifo #(.SIZE(SIZE), .AW(AW)) dut (
    .cmp_clk     (cmp_clk),
    .arst        (arst),
    .flush       (flush),
    .rx_sync     (rx_sync),
    .prevld      (prevld),
    .presyncdata (presyncdata),
    .tx_sync     (tx_sync),
    .syncdata    (syncdata),
    .syncvld     (syncvld),
    .occupancy   (occupancy),
    .overflow    (overflow)
  );

  always #5 cmp_clk = ~cmp_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given pulses; returns #1 after the edge.
  task automatic cyc(input logic rx, input logic vld, input logic [SIZE-1:0] d,
                     input logic tx, input logic fl);
    rx_sync     = rx;
    prevld      = vld;
    presyncdata = d;
    tx_sync     = tx;
    flush       = fl;
    @(posedge cmp_clk);
    #1;
    rx_sync     = 1'b0;
    prevld      = 1'b0;
    presyncdata = '0;
    tx_sync     = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic wr(input logic [SIZE-1:0] d);
    cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [SIZE-1:0] q[$];
    logic [SIZE-1:0] exp_data;
    logic            exp_vld;
    logic            rx, tx;
    int              wcount;

    arst = 1'b1; flush = 1'b0; rx_sync = 1'b0; prevld = 1'b0;
    presyncdata = '0; tx_sync = 1'b0;
    #12;
    check("rst_syncvld", syncvld, 0);
    check("rst_syncdata", syncdata, 0);
    check("rst_occ", occupancy, 0);
    check("rst_ovf", overflow, 0);
    @(negedge cmp_clk);
    arst = 1'b0;
    @(posedge cmp_clk); #1;

    // tx_sync on an empty queue
    rd();
    check("empty_rd_vld", syncvld, 0);
    check("empty_rd_data", syncdata, 0);
    check("empty_rd_occ", occupancy, 0);

    // Basic in-order transfer
    wr(8'h11); check("w1_occ", occupancy, 1);
    wr(8'h22); check("w2_occ", occupancy, 2);
    wr(8'h33); check("w3_occ", occupancy, 3);
    rd(); check("r1_data", syncdata, 8'h11); check("r1_vld", syncvld, 1); check("r1_occ", occupancy, 2);
    rd(); check("r2_data", syncdata, 8'h22); check("r2_vld", syncvld, 1);
    rd(); check("r3_data", syncdata, 8'h33); check("r3_vld", syncvld, 1); check("r3_occ", occupancy, 0);
    rd(); check("r4_vld", syncvld, 0); check("r4_data_hold", syncdata, 8'h33);
    // No tx_sync: outputs hold
    cyc(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    check("novld_occ", occupancy, 0);
    check("hold_data", syncdata, 8'h33);

    // Overflow: fill, then one extra sample with no read
    wr(8'hA0); wr(8'hA1); wr(8'hA2); wr(8'hA3);
    check("fill_occ", occupancy, 4);
    check("fill_ovf", overflow, 0);
    wr(8'hA4);
    check("ovf_occ", occupancy, 4);
    check("ovf_set", overflow, 1);
    rd(); check("ovf_r0", syncdata, 8'hA0);
    rd(); check("ovf_r1", syncdata, 8'hA1);
    rd(); check("ovf_r2", syncdata, 8'hA2);
    rd(); check("ovf_r3", syncdata, 8'hA3); check("ovf_r3_vld", syncvld, 1);
    rd(); check("ovf_r4_vld", syncvld, 0); check("ovf_r4_data", syncdata, 8'hA3);
    check("ovf_sticky", overflow, 1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("flush_ovf", overflow, 0);
    check("flush_data", syncdata, 0);

    // Full queue with simultaneous read and write
    wr(8'hB0); wr(8'hB1); wr(8'hB2); wr(8'hB3);
    cyc(1'b1, 1'b1, 8'hB4, 1'b1, 1'b0);
    check("fullrw_data", syncdata, 8'hB0);
    check("fullrw_occ", occupancy, 4);
    check("fullrw_ovf", overflow, 0);
    rd(); check("fullrw_r1", syncdata, 8'hB1);
    rd(); check("fullrw_r2", syncdata, 8'hB2);
    rd(); check("fullrw_r3", syncdata, 8'hB3);
    rd(); check("fullrw_r4", syncdata, 8'hB4); check("fullrw_occ0", occupancy, 0);

    // rx every 3 cycles, tx every 2: 20 writes, pointers wrap several times
    exp_data = 8'hB4;
    exp_vld  = 1'b1;
    wcount   = 0;
    for (int c = 0; c < 60; c++) begin
      rx = (c % 3 == 0);
      tx = (c % 2 == 1);
      if (tx) begin
        if (q.size() != 0) begin
          exp_data = q.pop_front();
          exp_vld  = 1'b1;
        end else begin
          exp_vld = 1'b0;
        end
      end
      if (rx) begin
        q.push_back(8'hC0 + 8'(wcount));
      end
      cyc(rx, rx, 8'hC0 + 8'(wcount), tx, 1'b0);
      if (rx) wcount++;
      if (tx) begin
        check("ratio_vld", syncvld, exp_vld);
        check("ratio_data", syncdata, exp_data);
      end
      check("ratio_occ", occupancy, q.size());
      check("ratio_occ_le4", occupancy <= 4, 1);
    end
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      exp_data = q.pop_front();
      rd();
      check("drain_data", syncdata, exp_data);
      check("drain_vld", syncvld, 1);
    end
    check("ratio_writes", wcount, 20);
    check("ratio_empty", occupancy, 0);

    // Flush concurrent with rx and tx, 2 entries queued, overflow set
    wr(8'hD0); wr(8'hD1); wr(8'hD2); wr(8'hD3); wr(8'hD4);
    check("pre_flush_ovf", overflow, 1);
    rd(); rd();
    check("pre_flush_occ", occupancy, 2);
    check("pre_flush_data", syncdata, 8'hD1);
    cyc(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    check("flush_occ", occupancy, 0);
    check("flush_vld", syncvld, 0);
    check("flush_data0", syncdata, 0);
    check("flush_ovf0", overflow, 0);
    rd();
    check("flush_nowrite_vld", syncvld, 0);
    check("flush_nowrite_occ", occupancy, 0);

    // Asynchronous reset between edges with 3 entries queued
    wr(8'hE1); wr(8'hE2); wr(8'hE3); wr(8'hE4);
    rd();
    wr(8'hE5); wr(8'hE6);
    check("pre_arst_occ", occupancy, 4);
    check("pre_arst_ovf", overflow, 1);
    rd();
    check("pre_arst_occ3", occupancy, 3);
    check("pre_arst_data", syncdata, 8'hE2);
    #2;
    arst = 1'b1;
    #1;
    check("arst_occ", occupancy, 0);
    check("arst_vld", syncvld, 0);
    check("arst_data", syncdata, 0);
    check("arst_ovf", overflow, 0);
    @(negedge cmp_clk);
    arst = 1'b0;
    @(posedge cmp_clk); #1;
    rd();
    check("post_arst_vld", syncvld, 0);
    check("post_arst_occ", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
